// File: rtl/rr_resource_arbiter_pkg.sv
// rr_resource_arbiter_pkg: shared FSM encoding and default sizing for the round-robin resource arbiter
package rr_resource_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;
    localparam int N_DEF = 4;
    localparam int IW_DEF = 2;
    localparam int MAX_HOLD_DEF = 16;
endpackage

// File: rtl/rr_resource_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr with wrap
module rr_pick
    import rr_resource_arbiter_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int IW = IW_DEF
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    always_comb begin
        valid = |req;
        idx = '0;
        j = '0;
        // Scan farthest offset first so the nearest request at or after ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin exclusive-ownership arbiter for one shared resource.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles with a timeout_err pulse.
module rr_resource_arbiter
    import rr_resource_arbiter_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int IW = IW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          timeout_err
);
    if (IW != $clog2(N) || N < 2 || N > 16 || MAX_HOLD < 1) begin : g_cfg_check
        $error("rr_resource_arbiter: inconsistent N/IW/MAX_HOLD");
    end
    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] id_q, id_d, ptr_q, ptr_d;
    logic          err_q, err_d;
    logic          pick_valid, rel_n, to;
    logic [IW-1:0] pick_idx;
    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
    assign rel_n = done[id_q] | ~req[id_q];
`ifdef ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HW-1:0] hold_q, hold_d;
    // A normal release on the last allowed cycle wins over the timeout.
    assign to = (hold_q == HW'(MAX_HOLD - 1)) & ~rel_n;
`else
    assign to = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        id_d = id_q;
        ptr_d = ptr_q;
        err_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d = hold_q + 1'b1;
`endif
        if (state_q == ST_IDLE) begin
            if (pick_valid) begin
                state_d = ST_GRANT;
                gnt_d = N'(1) << pick_idx;
                id_d = pick_idx;
`ifdef ARB_TIMEOUT_EN
                hold_d = '0;
`endif
            end
        end else if (rel_n || to) begin
            state_d = ST_IDLE;
            gnt_d = '0;
            id_d = '0;
            ptr_d = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
            err_d = to;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q <= '0;
            id_q <= '0;
            ptr_q <= '0;
            err_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            id_q <= id_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
`ifdef ARB_TIMEOUT_EN
            hold_q <= hold_d;
`endif
        end
    end
    assign gnt = gnt_q;
    assign gnt_id = id_q;
    assign busy = (state_q == ST_GRANT);
    assign timeout_err = err_q;
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter: directed vector table, timeout/hold sequence and random run against a reference model.
module tb_rr_resource_arbiter;
    localparam int N = 4;
    localparam int MAX_HOLD = 16;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy, timeout_err;
    int checks = 0;
    int errors = 0;
    rr_resource_arbiter #(.N(N), .IW(2), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );
    always #5 clk = ~clk;
    // Reference model: owner index (-1 = nobody), rotating start point, cycles held.
    int   m_own = -1;
    int   m_ptr = 0;
    int   m_hold = 0;
    logic m_err = 1'b0;
    task automatic model_edge(input logic r, input logic [3:0] rq, input logic [3:0] dn);
        bit rel, tmo;
        if (r) begin
            m_own = -1; m_ptr = 0; m_hold = 0; m_err = 1'b0;
        end else if (m_own < 0) begin
            m_err = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (rq[(m_ptr + k) % N]) begin
                    m_own = (m_ptr + k) % N;
                    m_hold = 0;
                    break;
                end
            end
        end else begin
            rel = dn[m_own] || !rq[m_own];
            tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo = !rel && (m_hold == MAX_HOLD - 1);
`endif
            if (rel || tmo) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
                m_err = tmo;
            end else begin
                m_hold++;
                m_err = 1'b0;
            end
        end
    endtask
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dn);
        rst = r; req = rq; done = dn;
        @(posedge clk);
        model_edge(r, rq, dn);
        #1;
    endtask
    task automatic chk(input string nm, input logic [3:0] g, input logic [1:0] id, input logic b, input logic e);
        checks++;
        if (gnt !== g || gnt_id !== id || busy !== b || timeout_err !== e) begin
            errors++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b err=%b, want gnt=%b id=%0d busy=%b err=%b",
                     nm, gnt, gnt_id, busy, timeout_err, g, id, b, e);
        end
    endtask
    task automatic chk_model(input string nm);
        logic [3:0] g;
        g = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
        chk(nm, g, (m_own < 0) ? 2'd0 : 2'(m_own), m_own >= 0, m_err);
    endtask
    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask
    typedef struct {
        string      nm;
        logic       r;
        logic [3:0] rq, dn, g;
        logic [1:0] id;
        logic       b, e;
    } vec_t;
    vec_t tv[$];
    task automatic add(input string nm, input logic r, input logic [3:0] rq, input logic [3:0] dn,
                       input logic [3:0] g, input logic [1:0] id, input logic b);
        vec_t v;
        v.nm = nm; v.r = r; v.rq = rq; v.dn = dn; v.g = g; v.id = id; v.b = b; v.e = 1'b0;
        tv.push_back(v);
    endtask
    initial begin
        int busy_cnt, err_cnt;
        logic [3:0] rq;
        add("reset0",     1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        add("reset1",     1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        add("single_gnt", 0, 4'b0100, 4'b0000, 4'b0100, 2, 1);
        add("single_h1",  0, 4'b0100, 4'b0000, 4'b0100, 2, 1);
        add("single_h2",  0, 4'b0100, 4'b0000, 4'b0100, 2, 1);
        add("single_rel", 0, 4'b0100, 4'b0100, 4'b0000, 0, 0);
        add("idle_noreq", 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add("rot_reset",  1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add("rot_g0",     0, 4'b1111, 4'b0000, 4'b0001, 0, 1);
        add("rot_r0",     0, 4'b1111, 4'b0001, 4'b0000, 0, 0);
        add("rot_g1",     0, 4'b1111, 4'b0000, 4'b0010, 1, 1);
        add("rot_r1",     0, 4'b1111, 4'b0010, 4'b0000, 0, 0);
        add("rot_g2",     0, 4'b1111, 4'b0000, 4'b0100, 2, 1);
        add("rot_r2",     0, 4'b1111, 4'b0100, 4'b0000, 0, 0);
        add("rot_g3",     0, 4'b1111, 4'b0000, 4'b1000, 3, 1);
        add("rot_r3",     0, 4'b1111, 4'b1000, 4'b0000, 0, 0);
        add("rot_g0wrap", 0, 4'b1111, 4'b0000, 4'b0001, 0, 1);
        add("rot_r0wrap", 0, 4'b1111, 4'b0001, 4'b0000, 0, 0);
        add("drop_g1",    0, 4'b0110, 4'b0000, 4'b0010, 1, 1);
        add("drop_nonown",0, 4'b0110, 4'b1000, 4'b0010, 1, 1);
        add("drop_rel",   0, 4'b0100, 4'b0000, 4'b0000, 0, 0);
        add("drop_g2",    0, 4'b0100, 4'b0000, 4'b0100, 2, 1);
        add("mid_rel2",   0, 4'b1000, 4'b0100, 4'b0000, 0, 0);
        add("mid_g3",     0, 4'b1000, 4'b0000, 4'b1000, 3, 1);
        add("mid_reset",  1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
        add("mid_g1",     0, 4'b1010, 4'b0000, 4'b0010, 1, 1);
        add("both_rel",   0, 4'b0000, 4'b0010, 4'b0000, 0, 0);
        add("idle_done",  0, 4'b0001, 4'b0001, 4'b0001, 0, 1);
        add("last_rel",   0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        foreach (tv[i]) begin
            step(tv[i].r, tv[i].rq, tv[i].dn);
            chk(tv[i].nm, tv[i].g, tv[i].id, tv[i].b, tv[i].e);
        end
        step(1, 4'b0000, 4'b0000);
        chk_model("hold_reset");
        step(0, 4'b0001, 4'b0000);
        chk("hold_gnt", 4'b0001, 0, 1, 0);
        busy_cnt = 0;
        err_cnt = 0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cnt++;
            step(0, 4'b0001, 4'b0000);
            chk_model("tmo_cycle");
            err_cnt += int'(timeout_err);
        end
        chk_int("tmo_hold_len", busy_cnt, MAX_HOLD);
        chk_int("tmo_err_pulses", err_cnt, 1);
        step(0, 4'b0001, 4'b0000);
        chk("tmo_regrant", 4'b0001, 0, 1, 0);
`else
        for (int i = 0; i < 110; i++) begin
            busy_cnt += int'(busy);
            step(0, 4'b0001, 4'b0000);
            chk_model("hold_cycle");
            err_cnt += int'(timeout_err);
        end
        chk_int("hold_len", busy_cnt, 110);
        chk_int("hold_err_pulses", err_cnt, 0);
`endif
        step(0, 4'b0000, 4'b0001);
        chk_model("hold_release");
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            step($urandom_range(0, 63) == 0, rq,
                 ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000);
            chk_model("random");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
